// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared state encoding and mode constants for the timer controller
package counter_sched_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/counter_core.sv
// counter_core: up-counter with synchronous clear (priority) and enable
module counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en) count <= count + WIDTH'(1);
endmodule

// File: rtl/counter_sched_ctrl.sv
// counter_sched_ctrl: programmable one-shot/periodic timer sequencing a counter_core
module counter_sched_ctrl
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] term_val,
  input  logic             mode_periodic,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);
  state_t state, nxt;
  logic [WIDTH-1:0] term_reg;
  logic mode_reg, clr, en, tick_n;
  counter_core #(.WIDTH(WIDTH)) u_core (.clk(clk), .rst(rst), .clr(clr), .en(en), .count(count));
  always_comb begin
    nxt = state;
    clr = 1'b0;
    en = 1'b0;
    tick_n = 1'b0;
    if (stop) begin
      nxt = ST_IDLE;
      clr = 1'b1;
    end else if (start && (state == ST_IDLE || state == ST_DONE)) begin
      nxt = ST_RUN;
      clr = 1'b1;
    end else if (state == ST_RUN && pause) nxt = ST_HOLD;
    else if (state == ST_HOLD && !pause) nxt = ST_RUN;
    else if (state == ST_RUN) begin
      if (count != term_reg) en = 1'b1;
      else begin
        tick_n = 1'b1;
        clr = mode_reg == MODE_PERIODIC;
        nxt = mode_reg == MODE_PERIODIC ? ST_RUN : ST_DONE;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      term_reg <= '0;
      mode_reg <= MODE_ONESHOT;
      tick <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      tick <= tick_n;
      done <= nxt == ST_DONE;
      busy <= nxt == ST_RUN || nxt == ST_HOLD;
      if (cfg_we && (state == ST_IDLE || state == ST_DONE)) begin
        term_reg <= term_val;
        mode_reg <= mode_periodic;
      end
    end
endmodule

// File: tb/tb_counter_sched_ctrl.sv
// tb_counter_sched_ctrl: directed stimulus with a queue scoreboard checked by a separate monitor
module tb_counter_sched_ctrl;
  logic clk = 0, rst = 1, cfg_we = 0, mode_periodic = 0, start = 0, pause = 0, stop = 0;
  logic [7:0] term_val = 0, count;
  logic busy, tick, done;
  int checks = 0, errors = 0;
  typedef struct packed {
    int id;
    logic [7:0] c;
    logic b, t, d;
  } exp_t;
  exp_t q[$];
  exp_t me;

  counter_sched_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .term_val(term_val), .mode_periodic(mode_periodic),
    .start(start), .pause(pause), .stop(stop), .count(count), .busy(busy), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (q.size() > 0) begin
      me = q.pop_front();
      checks++;
      if ({count, busy, tick, done} !== {me.c, me.b, me.t, me.d}) begin
        errors++;
        $display("FAIL test%0d chk%0d: got count=%0d busy=%b tick=%b done=%b, want count=%0d busy=%b tick=%b done=%b",
                 me.id, checks, count, busy, tick, done, me.c, me.b, me.t, me.d);
      end
    end

  task automatic cyc(input int id, input logic r, we, input logic [7:0] tv, input logic md, st, ps, sp,
                     input logic [7:0] c, input logic b, t, d);
    @(negedge clk);
    rst = r; cfg_we = we; term_val = tv; mode_periodic = md; start = st; pause = ps; stop = sp;
    @(posedge clk);
    #1 q.push_back('{id: id, c: c, b: b, t: t, d: d});
  endtask

  initial begin
    int n;
    // 1: reset dominates start
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 2: periodic term 5
    cyc(2, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) cyc(2, 0, 0, 0, 0, 0, 0, 0, 8'(i % 6), 1, i % 6 == 0, 0);
    cyc(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // 3: one-shot term 3, write in RUN ignored, restart from DONE
    cyc(3, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(3, 0, 1, 7, 1, 0, 0, 0, 2, 1, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1);
    cyc(3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1);
    cyc(3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) cyc(3, 0, 0, 0, 0, 0, 0, 0, 8'(i), 1, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1);
    cyc(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // 4: periodic term 9 with pause at count 4
    cyc(4, 0, 1, 9, 1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(4, 0, 0, 0, 0, 0, 0, 0, 8'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(4, 0, 0, 0, 0, 0, 1, 0, 4, 1, 0, 0);
    cyc(4, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    for (int i = 5; i <= 9; i++) cyc(4, 0, 0, 0, 0, 0, 0, 0, 8'(i), 1, 0, 0);
    cyc(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    // 5: stop beats start at count 6, then restart
    for (int i = 1; i <= 6; i++) cyc(5, 0, 0, 0, 0, 0, 0, 0, 8'(i), 1, 0, 0);
    cyc(5, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc(5, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // 6: term 0 periodic / one-shot, term 255 wrap
    cyc(6, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(6, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(6, 0, 1, 255, 1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 255; i++) cyc(6, 0, 0, 0, 0, 0, 0, 0, 8'(i), 1, 0, 0);
    cyc(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(6, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    // 7: reset mid-run overrides start
    cyc(7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_sched_ctrl.md
Name: counter_sched_ctrl

Overview:
Controller that sequences a free-running up counter as a programmable timer. It owns the counter's clear/enable, compares against a programmed terminal value, and supports one-shot and periodic (auto-reload) modes with pause and stop. It emits a single-cycle tick on each terminal event. It sits between software-style control strobes and the counter datapath, and drives event/timebase logic downstream.

Parameters:
WIDTH, 8, counter and terminal-value width in bits

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
cfg_we  input  1  write strobe for term_val and mode_periodic
term_val  input  WIDTH  terminal count value; period is term_val+1 cycles
mode_periodic  input  1  1 = auto-reload, 0 = one-shot (captured with cfg_we)
start  input  1  start strobe
pause  input  1  level; holds the count while high
stop  input  1  abort strobe; returns to IDLE
count  output  WIDTH  current count value
busy  output  1  high in RUN or HOLD
tick  output  1  one-cycle pulse on each terminal event
done  output  1  high while in DONE (one-shot finished)

Behaviour:
- Reset: state=IDLE, count=0, term_reg=0, mode_reg=0, busy=0, tick=0, done=0. All outputs are registered.
- States:
  - IDLE: count=0.
  - RUN: counting.
  - HOLD: paused, count frozen.
  - DONE: one-shot finished, count frozen at term_reg.
- Priority each edge: rst > stop > start > pause > counting.
- cfg_we: captures term_val and mode_periodic only in IDLE or DONE. It is ignored in RUN or HOLD, and the registers keep their old values.
- stop, from any state: next state IDLE, count=0, tick=0, done=0.
- start:
  - In IDLE or DONE: next state RUN, count=0, done=0.
  - In RUN or HOLD: ignored.
  - start and cfg_we on the same edge: the newly written values take effect for this run.
- RUN, pause=1: next state HOLD, count unchanged, no tick.
- HOLD, pause=0: next state RUN, count unchanged that edge; counting resumes on the following edge.
- RUN, pause=0, count != term_reg: count <= count+1, tick=0.
- RUN, pause=0, count == term_reg:
  - Periodic: count <= 0, tick <= 1, stay in RUN.
  - One-shot: state <= DONE, count holds term_reg, tick <= 1, done <= 1.
- tick: high for exactly one cycle per terminal event. Back-to-back ticks are allowed only when term_reg=0 (periodic).
- Latency: with start sampled at edge E0, count=0 after E0, and the first tick is visible after edge E0+term_reg+1. Periodic: tick every term_reg+1 cycles.
- term_reg=0:
  - Periodic: count stays 0 and tick is high every cycle.
  - One-shot: DONE and tick one edge after start.
- term_reg = 2^WIDTH-1: count wraps naturally to 0 at terminal. No overflow beyond WIDTH is possible.
- busy = (state==RUN || state==HOLD), registered with the state.
- Reset mid-run: immediate return to reset values on the next edge, regardless of the other inputs.

Decomposition:
- Package counter_sched_pkg:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2, ST_DONE=2'd3
  - mode constants: MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1
- Sub-module counter_core (WIDTH param; ports clk, rst, clr, en, count):
  - synchronous clear has priority over enable
  - increments when en
  - this is the existing up-counter extended with clr/en
- Controller holds the FSM, config registers and comparator. It drives clr/en and registers tick/done.

Test Plan:
1. Reset held 2 cycles with start=1 -> count=0, busy=0, tick=0, done=0, state IDLE.
2. cfg_we with term_val=5, mode_periodic=1, then start; run 20 cycles -> count sequence 0,1,2,3,4,5,0,...; tick pulses 6 cycles apart, first tick 6 edges after start.
3. term_val=3, one-shot, start -> count 0..3, tick once, done=1 and count held at 3. A second start clears done and reruns. cfg_we to term_val=7 while RUN is ignored.
4. Periodic term_val=9, pause high for 4 cycles at count=4 -> count holds 4, busy=1, no tick. After release, resume 5..9 and tick; period stretched by 5 cycles (4 held + 1 resume edge).
5. stop asserted at count=6 with start also high -> IDLE, count=0, busy=0, no tick. Start on the next cycle restarts from 0.
6. term_val=0 periodic -> tick high every cycle, count=0. term_val=255 (WIDTH=8) periodic -> tick after 256 cycles, count wraps 255->0.
